// File: rtl/recirculacion_param.sv
// Purpose: N-lane recirculation stage with a built-in idle sequencer. Words go to the rp path while IDLE and to the main path while ACTIVE.
// Latency: 1 clk_f cycle on both the main and rp paths. idle_out is the registered state bit.
// Backpressure: none. The downstream stage must accept a word every cycle. Optional per-lane counters are enabled by RECIRC_COUNT_EN.
module recirculacion_param #(
    parameter int LANES       = 4,
    parameter int WIDTH       = 8,
    parameter int IDLE_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic                     clk_f,
    input  logic                     reset,
    input  logic [LANES*WIDTH-1:0]   data_in,
    input  logic [LANES-1:0]         valid_in,
    input  logic                     force_idle,
    output logic [LANES*WIDTH-1:0]   data_out,
    output logic [LANES-1:0]         valid_out,
    output logic [LANES*WIDTH-1:0]   data_rp,
    output logic [LANES-1:0]         valid_rp,
    output logic                     idle_out
`ifdef RECIRC_COUNT_EN
    ,
    output logic [LANES*CNT_W-1:0]   recirc_count
`endif
);

    localparam int              IC_W    = $clog2(IDLE_CYCLES + 1);
    localparam logic [IC_W-1:0] IC_LAST = IC_W'(IDLE_CYCLES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IC_W-1:0] cnt_q;
    logic [IC_W-1:0] cnt_d;
    logic [LANES*WIDTH-1:0] masked_dat;

    // State and idle-cycle counter register
    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: force_idle takes priority over the counter's terminal count
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (force_idle) begin
                    cnt_d = '0;
                end else if (cnt_q == IC_LAST) begin
                    state_d = ST_ACTIVE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + IC_W'(1);
                end
            end
            ST_ACTIVE: begin
                if (force_idle) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Zero the data of lanes that are not valid so that no stale bytes leak downstream
    always_comb begin
        masked_dat = '0;
        for (int i = 0; i < LANES; i++) begin
            masked_dat[i*WIDTH +: WIDTH] = valid_in[i] ? data_in[i*WIDTH +: WIDTH] : '0;
        end
    end

    // Route each word by the pre-edge state, so the word on a state-change edge follows the old state
    always_ff @(posedge clk_f) begin
        if (reset) begin
            data_out  <= '0;
            valid_out <= '0;
            data_rp   <= '0;
            valid_rp  <= '0;
        end else if (state_q == ST_IDLE) begin
            data_out  <= '0;
            valid_out <= '0;
            data_rp   <= masked_dat;
            valid_rp  <= valid_in;
        end else begin
            data_out  <= masked_dat;
            valid_out <= valid_in;
            data_rp   <= '0;
            valid_rp  <= '0;
        end
    end

    assign idle_out = (state_q == ST_IDLE);

`ifdef RECIRC_COUNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [LANES*CNT_W-1:0] rc_q;

    // Count words that were recirculated on each lane. The count saturates and is cleared only by reset.
    always_ff @(posedge clk_f) begin
        if (reset) begin
            rc_q <= '0;
        end else begin
            for (int i = 0; i < LANES; i++) begin
                if ((state_q == ST_IDLE) && valid_in[i] &&
                    (rc_q[i*CNT_W +: CNT_W] != CNT_MAX)) begin
                    rc_q[i*CNT_W +: CNT_W] <= rc_q[i*CNT_W +: CNT_W] + CNT_W'(1);
                end
            end
        end
    end

    assign recirc_count = rc_q;
`endif

endmodule

// File: tb/tb_recirculacion_param.sv
// Purpose: directed bench for recirculacion_param. It covers routing, lane masking, the idle sequencer, force_idle, reset and the optional counters.
// Latency: outputs are checked 1 ns after each rising edge, which is one cycle after the inputs are driven.
// Backpressure: none. The stimulus presents a word every cycle.
module tb_recirculacion_param;

    localparam int LANES       = 4;
    localparam int WIDTH       = 8;
    localparam int IDLE_CYCLES = 4;
`ifdef RECIRC_COUNT_EN
    localparam int CNT_W       = 2;
`else
    localparam int CNT_W       = 8;
`endif

    logic                   clk_f;
    logic                   reset;
    logic [LANES*WIDTH-1:0] data_in;
    logic [LANES-1:0]       valid_in;
    logic                   force_idle;
    logic [LANES*WIDTH-1:0] data_out;
    logic [LANES-1:0]       valid_out;
    logic [LANES*WIDTH-1:0] data_rp;
    logic [LANES-1:0]       valid_rp;
    logic                   idle_out;
`ifdef RECIRC_COUNT_EN
    logic [LANES*CNT_W-1:0] recirc_count;
`endif

    int checks = 0;
    int errors = 0;

    recirculacion_param #(
        .LANES       (LANES),
        .WIDTH       (WIDTH),
        .IDLE_CYCLES (IDLE_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk_f        (clk_f),
        .reset        (reset),
        .data_in      (data_in),
        .valid_in     (valid_in),
        .force_idle   (force_idle),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .data_rp      (data_rp),
        .valid_rp     (valid_rp),
        .idle_out     (idle_out)
`ifdef RECIRC_COUNT_EN
        ,
        .recirc_count (recirc_count)
`endif
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    // Advance one rising edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag,
                            input logic [31:0] e_dout, input logic [3:0] e_vout,
                            input logic [31:0] e_drp,  input logic [3:0] e_vrp,
                            input logic e_idle);
        chk({tag, ".data_out"},  64'(data_out),  64'(e_dout));
        chk({tag, ".valid_out"}, 64'(valid_out), 64'(e_vout));
        chk({tag, ".data_rp"},   64'(data_rp),   64'(e_drp));
        chk({tag, ".valid_rp"},  64'(valid_rp),  64'(e_vrp));
        chk({tag, ".idle_out"},  64'(idle_out),  64'(e_idle));
    endtask

    initial begin
        reset      = 1'b1;
        force_idle = 1'b0;
        data_in    = '0;
        valid_in   = '0;
        tick();
        tick();
        chk_outs("reset", 32'h0, 4'h0, 32'h0, 4'h0, 1'b1);
`ifdef RECIRC_COUNT_EN
        chk("rc_after_reset", 64'(recirc_count), 64'h0);
`endif

        // Release reset. While IDLE, valid words go to the rp path.
        reset    = 1'b0;
        data_in  = 32'hDDCC_BBAA;
        valid_in = 4'hF;
        tick();                                              // edge 1 after release
        chk_outs("idle_rp", 32'h0, 4'h0, 32'hDDCC_BBAA, 4'hF, 1'b1);

        data_in  = 32'h1234_5678;
        valid_in = 4'b0110;
        tick();                                              // edge 2
        chk_outs("idle_mask", 32'h0, 4'h0, 32'h0034_5600, 4'h6, 1'b1);

        data_in  = '0;
        valid_in = '0;
        tick();                                              // edge 3
        chk("idle_edge3", 64'(idle_out), 64'h1);

        // Edge 4 changes the state. The word sampled on it still follows IDLE.
        data_in  = 32'h0102_0304;
        valid_in = 4'hF;
        tick();
        chk_outs("state_change", 32'h0, 4'h0, 32'h0102_0304, 4'hF, 1'b0);

        // While ACTIVE, words go to the main path with per-lane masking.
        data_in  = 32'h4433_2211;
        valid_in = 4'b0101;
        tick();
        chk_outs("active_0101", 32'h0033_0011, 4'h5, 32'h0, 4'h0, 1'b0);

        data_in  = 32'hAABB_CCDD;
        valid_in = 4'b1010;
        tick();
        chk_outs("active_1010", 32'hAA00_CC00, 4'hA, 32'h0, 4'h0, 1'b0);

        // A one-cycle force_idle pulse. Its own word still leaves on the main path.
        force_idle = 1'b1;
        data_in    = 32'h0000_0055;
        valid_in   = 4'b0001;
        tick();
        chk_outs("force_edge", 32'h0000_0055, 4'h1, 32'h0, 4'h0, 1'b1);

        force_idle = 1'b0;
        data_in    = 32'h0000_6600;
        valid_in   = 4'b0010;
        tick();                                              // edge 1 after drop
        chk_outs("after_force", 32'h0, 4'h0, 32'h0000_6600, 4'h2, 1'b1);
        data_in  = '0;
        valid_in = '0;
        tick();
        chk("reactivate_e2", 64'(idle_out), 64'h1);
        tick();
        chk("reactivate_e3", 64'(idle_out), 64'h1);
        tick();
        chk("reactivate_e4", 64'(idle_out), 64'h0);

        // force_idle on the terminal-count edge: force_idle wins and the counter restarts.
        force_idle = 1'b1;
        tick();
        force_idle = 1'b0;
        tick();
        tick();
        tick();                                              // counter now at terminal value
        chk("pre_terminal", 64'(idle_out), 64'h1);
        force_idle = 1'b1;
        tick();
        chk("force_wins", 64'(idle_out), 64'h1);
        force_idle = 1'b0;
        tick();
        tick();
        tick();
        chk("force_wins_cnt0", 64'(idle_out), 64'h1);
        tick();
        chk("force_wins_active", 64'(idle_out), 64'h0);

        // Reset while ACTIVE with traffic clears everything on the next edge.
        data_in  = 32'hFFFF_FFFF;
        valid_in = 4'hF;
        tick();
        chk_outs("active_full", 32'hFFFF_FFFF, 4'hF, 32'h0, 4'h0, 1'b0);
        reset = 1'b1;
        tick();
        chk_outs("mid_reset", 32'h0, 4'h0, 32'h0, 4'h0, 1'b1);
        reset = 1'b0;
        tick();
        chk_outs("post_reset_e1", 32'h0, 4'h0, 32'hFFFF_FFFF, 4'hF, 1'b1);
        tick();
        tick();
        chk("post_reset_e3", 64'(idle_out), 64'h1);
        tick();
        chk("post_reset_e4", 64'(idle_out), 64'h0);

`ifdef RECIRC_COUNT_EN
        // Hold IDLE and recirculate lane 0 only. A 2-bit counter saturates at 3.
        reset      = 1'b1;
        force_idle = 1'b1;
        data_in    = 32'h0000_0001;
        valid_in   = 4'b0001;
        tick();
        chk("rc_cleared", 64'(recirc_count), 64'h0);
        reset = 1'b0;
        tick();
        tick();
        chk("rc_two", 64'(recirc_count), 64'h02);
        tick();
        tick();
        tick();
        chk("rc_saturate", 64'(recirc_count), 64'h03);
        chk("rc_still_idle", 64'(idle_out), 64'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
